// File: rtl/alu8.sv
`default_nettype none
// ============================================================================
// Module   : alu8
// Brief    : 8-bit registered ALU, opcode-selected result plus carry/overflow.
// Revision : 1.0 - initial release
// ============================================================================
module alu8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    output logic [7:0] r,
    output logic       c,
    output logic       v
);

    localparam logic [3:0] C_OP_AND   = 4'b1110;
    localparam logic [3:0] C_OP_OR    = 4'b1101;
    localparam logic [3:0] C_OP_NOT   = 4'b1100;
    localparam logic [3:0] C_OP_XOR   = 4'b1011;
    localparam logic [3:0] C_OP_ADD   = 4'b1010;
    localparam logic [3:0] C_OP_SUB   = 4'b1001;
    localparam logic [3:0] C_OP_XFER  = 4'b1000;
    localparam logic [3:0] C_OP_TEST  = 4'b0111;
    localparam logic [3:0] C_OP_INC   = 4'b0110;
    localparam logic [3:0] C_OP_DEC   = 4'b0101;
    localparam logic [3:0] C_OP_SHL   = 4'b0100;
    localparam logic [3:0] C_OP_SHR   = 4'b0011;
    localparam logic [3:0] C_OP_ASR   = 4'b0010;

    localparam logic [7:0] C_ONE      = 8'h01;
    localparam logic [7:0] C_MAX_POS  = 8'h7F;
    localparam logic [7:0] C_MIN_NEG  = 8'h80;

    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [8:0] w_inc;
    logic [8:0] w_dec;
    logic [7:0] w_r;
    logic       w_c;
    logic       w_v;

    logic [7:0] r_res;
    logic       r_carry;
    logic       r_ovf;

    // Bit 8 of the 9-bit difference is the unsigned borrow (set when a < b).
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_inc  = {1'b0, a} + {1'b0, C_ONE};
    assign w_dec  = {1'b0, a} - {1'b0, C_ONE};

    always_comb begin
        w_r = 8'h00;
        w_c = 1'b0;
        w_v = 1'b0;
        case (s)
            C_OP_AND:  w_r = a & b;
            C_OP_OR:   w_r = a | b;
            C_OP_NOT:  w_r = ~a;
            C_OP_XOR:  w_r = a ^ b;
            C_OP_ADD: begin
                w_r = w_sum[7:0];
                w_c = w_sum[8];
                w_v = (a[7] == b[7]) && (w_sum[7] != a[7]);
            end
            C_OP_SUB: begin
                w_r = w_diff[7:0];
                w_c = w_diff[8];
                w_v = (a[7] != b[7]) && (w_diff[7] != a[7]);
            end
            C_OP_XFER: w_r = a;
            C_OP_TEST: w_r = (a == 8'h00) ? C_ONE : 8'h00;
            C_OP_INC: begin
                w_r = w_inc[7:0];
                w_c = w_inc[8];
                w_v = (a == C_MAX_POS);
            end
            C_OP_DEC: begin
                w_r = w_dec[7:0];
                w_c = w_dec[8];
                w_v = (a == C_MIN_NEG);
            end
            C_OP_SHL: begin
                w_r = {a[6:0], 1'b0};
                w_c = a[7];
            end
            C_OP_SHR: begin
                w_r = {1'b0, a[7:1]};
                w_c = a[0];
            end
            C_OP_ASR: begin
                w_r = {a[7], a[7:1]};
                w_c = a[0];
            end
            default: begin
                w_r = 8'h00;
                w_c = 1'b0;
                w_v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res   <= 8'h00;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_res   <= w_r;
            r_carry <= w_c;
            r_ovf   <= w_v;
        end
    end

    assign r = r_res;
    assign c = r_carry;
    assign v = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu8.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu8
// Brief    : Self-checking bench for alu8: arithmetic reference model plus
//            directed vectors with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;

    int n_cmp;
    int n_bad;
    logic       cmp_en;
    logic [7:0] exp_r;
    logic       exp_c;
    logic       exp_v;

    alu8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .s     (s),
        .r     (r),
        .c     (c),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic logic [9:0] model(input logic [7:0] ia, input logic [7:0] ib,
                                         input logic [3:0] is);
        int ua;
        int ub;
        int sa;
        int sb;
        int t;
        logic [7:0] rr;
        logic cc;
        logic vv;
        ua = int'(ia);
        ub = int'(ib);
        sa = int'($signed(ia));
        sb = int'($signed(ib));
        rr = 8'h00;
        cc = 1'b0;
        vv = 1'b0;
        case (is)
            4'hE: rr = ia & ib;
            4'hD: rr = ia | ib;
            4'hC: rr = ~ia;
            4'hB: rr = ia ^ ib;
            4'hA: begin
                t  = ua + ub;
                rr = 8'(t);
                cc = (t > 255);
                vv = ((sa + sb) > 127) || ((sa + sb) < -128);
            end
            4'h9: begin
                t  = ua - ub;
                rr = 8'(t);
                cc = (ua < ub);
                vv = ((sa - sb) > 127) || ((sa - sb) < -128);
            end
            4'h8: rr = ia;
            4'h7: rr = (ua == 0) ? 8'h01 : 8'h00;
            4'h6: begin
                t  = ua + 1;
                rr = 8'(t);
                cc = (t > 255);
                vv = (sa + 1) > 127;
            end
            4'h5: begin
                rr = 8'(ua - 1);
                cc = (ua == 0);
                vv = (sa - 1) < -128;
            end
            4'h4: begin
                rr = 8'(ua * 2);
                cc = (ua >= 128);
            end
            4'h3: begin
                rr = 8'(ua / 2);
                cc = ((ua % 2) == 1);
            end
            4'h2: begin
                t  = sa >>> 1;
                rr = 8'(t);
                cc = ((ua % 2) == 1);
            end
            default: rr = 8'h00;
        endcase
        return {vv, cc, rr};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_r <= 8'h00;
            exp_c <= 1'b0;
            exp_v <= 1'b0;
        end else begin
            {exp_v, exp_c, exp_r} <= model(a, b, s);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_cmp = n_cmp + 1;
            if (r !== exp_r || c !== exp_c || v !== exp_v) begin
                n_bad = n_bad + 1;
                $display("FAIL model t=%0t: got r=%h c=%b v=%b, want r=%h c=%b v=%b",
                         $time, r, c, v, exp_r, exp_c, exp_v);
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] er, input logic ec, input logic ev);
        n_cmp = n_cmp + 1;
        if (r !== er || c !== ec || v !== ev) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got r=%h c=%b v=%b, want r=%h c=%b v=%b",
                     nm, r, c, v, er, ec, ev);
        end
    endtask

    // Drives one operation just after an edge, checks it one edge later.
    task automatic run(input string nm, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [3:0] is, input logic [7:0] er,
                       input logic ec, input logic ev);
        a = ia;
        b = ib;
        s = is;
        @(posedge clk);
        #1;
        check(nm, er, ec, ev);
    endtask

    logic [7:0] ops_a [8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF, 8'h5A, 8'hC3};
    logic [7:0] ops_b [4] = '{8'h00, 8'h01, 8'h80, 8'hFF};
    logic [7:0] held_r;
    logic       held_c;
    logic       held_v;

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        a = 8'hFF;
        b = 8'hFF;
        s = 4'b1010;
        #23;
        check("reset_hold", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold2", 8'h00, 1'b0, 1'b0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run("and",   8'h95, 8'h35, 4'b1110, 8'h15, 1'b0, 1'b0);
        run("or",    8'h95, 8'hC9, 4'b1101, 8'hDD, 1'b0, 1'b0);
        run("not",   8'h95, 8'hFF, 4'b1100, 8'h6A, 1'b0, 1'b0);
        run("xor",   8'h5A, 8'h94, 4'b1011, 8'hCE, 1'b0, 1'b0);
        run("add1",  8'h01, 8'h01, 4'b1010, 8'h02, 1'b0, 1'b0);
        run("add2",  8'h0F, 8'h03, 4'b1010, 8'h12, 1'b0, 1'b0);
        run("add3",  8'hFF, 8'h01, 4'b1010, 8'h00, 1'b1, 1'b0);
        run("add4",  8'h7F, 8'h01, 4'b1010, 8'h80, 1'b0, 1'b1);
        run("add5",  8'h80, 8'h80, 4'b1010, 8'h00, 1'b1, 1'b1);
        run("sub1",  8'h81, 8'h81, 4'b1001, 8'h00, 1'b0, 1'b0);
        run("sub2",  8'h00, 8'h01, 4'b1001, 8'hFF, 1'b1, 1'b0);
        run("sub3",  8'h80, 8'h01, 4'b1001, 8'h7F, 1'b0, 1'b1);
        run("sub4",  8'h7F, 8'hFF, 4'b1001, 8'h80, 1'b1, 1'b1);
        run("xfer",  8'h07, 8'hAA, 4'b1000, 8'h07, 1'b0, 1'b0);
        run("test0", 8'h00, 8'hAA, 4'b0111, 8'h01, 1'b0, 1'b0);
        run("testF", 8'hFF, 8'hAA, 4'b0111, 8'h00, 1'b0, 1'b0);
        run("inc7F", 8'h7F, 8'h00, 4'b0110, 8'h80, 1'b0, 1'b1);
        run("incFF", 8'hFF, 8'h00, 4'b0110, 8'h00, 1'b1, 1'b0);
        run("dec00", 8'h00, 8'h00, 4'b0101, 8'hFF, 1'b1, 1'b0);
        run("dec80", 8'h80, 8'h00, 4'b0101, 8'h7F, 1'b0, 1'b1);
        run("shl",   8'h81, 8'h00, 4'b0100, 8'h02, 1'b1, 1'b0);
        run("shr",   8'h81, 8'h00, 4'b0011, 8'h40, 1'b1, 1'b0);
        run("asr",   8'h81, 8'h00, 4'b0010, 8'hC0, 1'b1, 1'b0);
        run("asr2",  8'h42, 8'h00, 4'b0010, 8'h21, 1'b0, 1'b0);
        run("clr1",  8'hFF, 8'hFF, 4'b0001, 8'h00, 1'b0, 1'b0);
        run("clr0",  8'hFF, 8'hFF, 4'b0000, 8'h00, 1'b0, 1'b0);

        // Latency: a mid-cycle input change must not reach the outputs.
        run("pre_lat", 8'h7F, 8'h01, 4'b1010, 8'h80, 1'b0, 1'b1);
        held_r = r;
        held_c = c;
        held_v = v;
        #1;
        a = 8'h00;
        b = 8'h00;
        s = 4'b0101;
        #2;
        check("latency_hold", held_r, held_c, held_v);
        @(posedge clk);
        #1;
        check("latency_next", 8'hFF, 1'b1, 1'b0);

        // Async reset between edges.
        run("pre_rst", 8'h7F, 8'h00, 4'b0110, 8'h80, 1'b0, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("after_release", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("first_edge", 8'h80, 1'b0, 1'b1);

        // Sweep every opcode over boundary operands; the model checks each cycle.
        for (int op = 0; op < 16; op++) begin
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 4; j++) begin
                    a = ops_a[i];
                    b = ops_b[j];
                    s = 4'(op);
                    @(posedge clk);
                    #1;
                end
            end
        end

        @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
